// File: rtl/gray2bin_pipe.sv
// Gray-to-binary decoder with a single valid/ready result register.
// Optional adjacency checker (single-bit step between consecutive codes) enabled by GRAY2BIN_ADJ_CHECK_EN.
module gray2bin_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  input  logic             chk_clr,
  output logic             adj_err,
  output logic [15:0]      err_cnt
);

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = {WIDTH{1'b0}};
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [4:0] popcount(input logic [WIDTH-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_bin;
  logic [WIDTH-1:0] w_bin;
  logic             w_in_xfer;

  assign w_bin     = gray_to_bin(in_gray);
  assign in_ready  = ~r_out_valid | out_ready;
  assign w_in_xfer = in_valid & in_ready;
  assign out_valid = r_out_valid;
  assign out_bin   = r_out_bin;

  // Result register: load on input transfer, drain on an output transfer alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_bin   <= {WIDTH{1'b0}};
    end else if (w_in_xfer) begin
      r_out_valid <= 1'b1;
      r_out_bin   <= w_bin;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

`ifdef GRAY2BIN_ADJ_CHECK_EN
  logic [WIDTH-1:0] r_prev_gray;
  logic             r_have_prev;
  logic             r_adj_err;
  logic [15:0]      r_err_cnt;
  logic             w_adj;

  // A code transferred alongside chk_clr is a fresh first code and is never flagged
  assign w_adj   = r_have_prev & ~chk_clr & (popcount(in_gray ^ r_prev_gray) != 5'd1);
  assign adj_err = r_adj_err;
  assign err_cnt = r_err_cnt;

  // Per-result error flag travels with the result register and drops when it drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adj_err <= 1'b0;
    end else if (w_in_xfer) begin
      r_adj_err <= w_adj;
    end else if (out_ready) begin
      r_adj_err <= 1'b0;
    end else begin
      r_adj_err <= r_adj_err;
    end
  end

  // Adjacency history and saturating error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_gray <= {WIDTH{1'b0}};
      r_have_prev <= 1'b0;
      r_err_cnt   <= 16'd0;
    end else if (w_in_xfer) begin
      r_prev_gray <= in_gray;
      r_have_prev <= 1'b1;
      if (chk_clr) begin
        r_err_cnt <= 16'd0;
      end else if (w_adj && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end else if (chk_clr) begin
      r_have_prev <= 1'b0;
      r_err_cnt   <= 16'd0;
    end else begin
      r_have_prev <= r_have_prev;
    end
  end
`else
  logic w_unused_chk_clr;

  assign w_unused_chk_clr = chk_clr;
  assign adj_err          = 1'b0;
  assign err_cnt          = 16'd0;
`endif

endmodule

// File: tb/tb_gray2bin_pipe.sv
// Directed self-checking bench for gray2bin_pipe (WIDTH=8); expectations follow
// whether GRAY2BIN_ADJ_CHECK_EN is defined for the build.
module tb_gray2bin_pipe;

`ifdef GRAY2BIN_ADJ_CHECK_EN
  localparam bit ADJ = 1'b1;
`else
  localparam bit ADJ = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_gray;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_bin;
  logic        chk_clr;
  logic        adj_err;
  logic [15:0] err_cnt;

  int n_tests;
  int n_fail;

  gray2bin_pipe #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_gray  (in_gray),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bin  (out_bin),
    .chk_clr  (chk_clr),
    .adj_err  (adj_err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] g;
    logic [7:0] b;
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_gray   = 8'h00;
    out_ready = 1'b1;
    chk_clr   = 1'b0;

    // Reset state
    #12;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_bin", {24'd0, out_bin}, 32'd0);
    check_eq("rst_adj_err", {31'd0, adj_err}, 32'd0);
    check_eq("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    cyc();

    // Exhaustive walk 0..255 then wrap to 0
    in_valid = 1'b1;
    for (int n = 0; n <= 256; n++) begin
      b = n[7:0];
      g = b ^ (b >> 1);
      in_gray = g;
      #1;
      check_eq("exh_in_ready", {31'd0, in_ready}, 32'd1);
      cyc();
      check_eq("exh_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("exh_out_bin", {24'd0, out_bin}, {24'd0, b});
      check_eq("exh_adj_err", {31'd0, adj_err}, 32'd0);
    end
    check_eq("exh_err_cnt", {16'd0, err_cnt}, 32'd0);
    in_valid = 1'b0;
    cyc();
    check_eq("drain_out_valid", {31'd0, out_valid}, 32'd0);

    // Stall: 8'h03 accepted, then 8'h02 held off for three cycles
    chk_clr = 1'b1;
    cyc();
    chk_clr  = 1'b0;
    in_valid = 1'b1;
    in_gray  = 8'h03;
    cyc();
    check_eq("stall_first_bin", {24'd0, out_bin}, 32'h02);
    check_eq("stall_first_adj", {31'd0, adj_err}, 32'd0);
    out_ready = 1'b0;
    in_gray   = 8'h02;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
      cyc();
      check_eq("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stall_out_bin", {24'd0, out_bin}, 32'h02);
      check_eq("stall_adj_err", {31'd0, adj_err}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("release_in_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    check_eq("release_out_bin", {24'd0, out_bin}, 32'h03);
    check_eq("release_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("release_adj_err", {31'd0, adj_err}, 32'd0);
    in_valid = 1'b0;
    cyc();
    check_eq("stall_drain", {31'd0, out_valid}, 32'd0);

    // Adjacency: 00, 03, 03
    chk_clr = 1'b1;
    cyc();
    chk_clr  = 1'b0;
    in_valid = 1'b1;
    in_gray  = 8'h00;
    cyc();
    check_eq("adj0_err", {31'd0, adj_err}, 32'd0);
    in_gray = 8'h03;
    cyc();
    check_eq("adj1_bin", {24'd0, out_bin}, 32'h02);
    check_eq("adj1_err", {31'd0, adj_err}, {31'd0, ADJ});
    cyc();
    check_eq("adj2_err", {31'd0, adj_err}, {31'd0, ADJ});
    check_eq("adj2_cnt", {16'd0, err_cnt}, ADJ ? 32'd2 : 32'd0);

    // chk_clr alongside transfer of 8'h55, then 8'h54, then a repeat
    chk_clr = 1'b1;
    in_gray = 8'h55;
    cyc();
    chk_clr = 1'b0;
    check_eq("clr_cnt", {16'd0, err_cnt}, 32'd0);
    check_eq("clr_adj", {31'd0, adj_err}, 32'd0);
    check_eq("clr_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("clr_out_bin", {24'd0, out_bin}, 32'h66);
    in_gray = 8'h54;
    cyc();
    check_eq("post_clr_adj", {31'd0, adj_err}, 32'd0);
    check_eq("post_clr_bin", {24'd0, out_bin}, 32'h67);
    cyc();
    check_eq("repeat_adj", {31'd0, adj_err}, {31'd0, ADJ});
    check_eq("repeat_cnt", {16'd0, err_cnt}, ADJ ? 32'd1 : 32'd0);

    // Reset while a result is stalled
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cyc();
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_bin", {24'd0, out_bin}, 32'd0);
    check_eq("mid_rst_cnt", {16'd0, err_cnt}, 32'd0);
    check_eq("mid_rst_adj", {31'd0, adj_err}, 32'd0);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_gray   = 8'h03;
    cyc();
    check_eq("after_rst_bin", {24'd0, out_bin}, 32'h02);
    check_eq("after_rst_adj", {31'd0, adj_err}, 32'd0);
    check_eq("after_rst_cnt", {16'd0, err_cnt}, 32'd0);
    in_valid = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
